// File: rtl/pll_sup_pkg.sv
// Package: pll_sup_pkg
// Shared types and constants for the PLL lock supervisor.
//   pll_state_e    : supervisor FSM state encoding (exported on the debug state port)
//   LOSS_COUNT_MAX : saturation value of the lock-loss counter
//   cnt_width()    : width of the shared phase counter for a given largest cycle count
//   max_of()       : helper to pick the largest of the cycle-count parameters
package pll_sup_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        FILTER    = 3'd2,
        HOLD      = 3'd3,
        RUN       = 3'd4,
        FAIL      = 3'd5
    } pll_state_e;

    localparam logic [7:0] LOSS_COUNT_MAX = 8'd255;

    function automatic int unsigned max_of(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to hold 0..max_val; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        int unsigned w;
        w = $clog2(max_val + 1);
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/pll_lock_supervisor_lock_sync.sv
// Module: lock_sync
// Two-flop synchroniser for the asynchronous PLL LOCK signal, with a synchronous clear so
// that a stale lock level cannot leak across a supervisor reset.
//   clk   in  : destination clock
//   clear in  : synchronous, active-high; forces both stages to 0
//   d     in  : asynchronous input
//   q     out : synchronised output, two cycles behind d
module lock_sync (
    input  logic clk,
    input  logic clear,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (clear) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_supervisor.sv
// Module: pll_lock_supervisor
// Sequences a PLL and the downstream reset tree: pulses the PLL reset, waits for and
// qualifies lock, holds the system reset a while longer, then releases it. Any lock loss
// restarts the sequence. Runs on the PLL reference clock, never on a PLL output.
// Optional feature: define PLL_WATCHDOG_EN to enable the WAIT_LOCK timeout/retry watchdog;
// without it WAIT_LOCK waits forever and fail/retries are tied to 0.
// Ports:
//   clk        in      PLL reference clock
//   reset      in      synchronous, active-high
//   pll_lock   in      PLL LOCK, asynchronous to clk
//   pll_reset  out     PLL RESET drive
//   sys_reset  out     synchronous active-high reset for downstream logic
//   ready      out     high only in RUN
//   fail       out     watchdog gave up (watchdog build only)
//   retries    out [3] timeouts since last RUN (watchdog build only)
//   loss_count out [8] lock losses seen in RUN, saturating
//   state      out [3] current FSM state
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int unsigned RST_PULSE_CYCLES   = 16,
    parameter int unsigned LOCK_FILTER_CYCLES = 1024,
    parameter int unsigned HOLD_CYCLES        = 4096,
    parameter int unsigned TIMEOUT_CYCLES     = 500000,
    parameter int unsigned MAX_RETRIES        = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic       sys_reset,
    output logic       ready,
    output logic       fail,
    output logic [2:0] retries,
    output logic [7:0] loss_count,
    output logic [2:0] state
);

    localparam int unsigned MAX_PARAM = max_of(max_of(max_of(RST_PULSE_CYCLES,
                                                             LOCK_FILTER_CYCLES),
                                                      max_of(HOLD_CYCLES, TIMEOUT_CYCLES)),
                                               MAX_RETRIES);
    localparam int unsigned CNT_W = cnt_width(MAX_PARAM);

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] FILTER_LAST = CNT_W'(LOCK_FILTER_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);

    logic             lock_s;
    logic [CNT_W-1:0] cnt;
    pll_state_e       state_q;
    pll_state_e       state_d;

    lock_sync u_lock_sync (
        .clk   (clk),
        .clear (reset),
        .d     (pll_lock),
        .q     (lock_s)
    );

`ifdef PLL_WATCHDOG_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]       RETRY_LIMIT  = 3'(MAX_RETRIES);

    logic [2:0] retries_q;
    logic [2:0] retries_d;
    logic       fail_q;

    assign retries = retries_q;
    assign fail    = fail_q;
`else
    assign retries = 3'd0;
    assign fail    = 1'b0;
`endif

    assign state = state_q;

    always_comb begin
        state_d = state_q;
`ifdef PLL_WATCHDOG_EN
        retries_d = retries_q;
`endif
        unique case (state_q)
            PLL_RST: begin
                if (cnt == RST_LAST) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                // A lock seen on the timeout cycle still wins over the retry.
                if (lock_s) begin
                    state_d = FILTER;
                end
`ifdef PLL_WATCHDOG_EN
                else if (cnt == TIMEOUT_LAST) begin
                    retries_d = retries_q + 3'd1;
                    state_d   = (retries_d == RETRY_LIMIT) ? FAIL : PLL_RST;
                end
`endif
            end
            FILTER: begin
                if (!lock_s)                 state_d = WAIT_LOCK;
                else if (cnt == FILTER_LAST) state_d = HOLD;
            end
            HOLD: begin
                if (!lock_s)               state_d = WAIT_LOCK;
                else if (cnt == HOLD_LAST) state_d = RUN;
            end
            RUN: begin
                if (!lock_s) state_d = PLL_RST;
            end
            FAIL: begin
                state_d = FAIL;
            end
            default: state_d = PLL_RST;
        endcase
`ifdef PLL_WATCHDOG_EN
        if (state_d == RUN) retries_d = 3'd0;
`endif
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= PLL_RST;
            cnt        <= '0;
            pll_reset  <= 1'b1;
            sys_reset  <= 1'b1;
            ready      <= 1'b0;
            loss_count <= 8'd0;
`ifdef PLL_WATCHDOG_EN
            retries_q  <= 3'd0;
            fail_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt       <= (state_d != state_q) ? '0 : cnt + 1'b1;
            pll_reset <= (state_d == PLL_RST) || (state_d == FAIL);
            sys_reset <= (state_d != RUN);
            ready     <= (state_d == RUN);
            if (state_q == RUN && state_d == PLL_RST && loss_count != LOSS_COUNT_MAX) begin
                loss_count <= loss_count + 8'd1;
            end
`ifdef PLL_WATCHDOG_EN
            retries_q <= retries_d;
            fail_q    <= (state_d == FAIL);
`endif
        end
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Testbench for pll_lock_supervisor: a behavioural model tracks phase and time-in-phase,
// a compare process checks every output on each falling edge, and directed sections pin the
// model with hand-computed literal expectations. Follows PLL_WATCHDOG_EN like the DUT.
module tb_pll_lock_supervisor;

    localparam int RST  = 4;
    localparam int FILT = 8;
    localparam int HLD  = 16;
    localparam int TO   = 100;
    localparam int MR   = 3;
`ifdef PLL_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pll_lock = 1'b0;
    logic       pll_reset, sys_reset, ready, fail;
    logic [2:0] retries, state;
    logic [7:0] loss_count;

    pll_lock_supervisor #(
        .RST_PULSE_CYCLES   (RST),
        .LOCK_FILTER_CYCLES (FILT),
        .HOLD_CYCLES        (HLD),
        .TIMEOUT_CYCLES     (TO),
        .MAX_RETRIES        (MR)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pll_lock   (pll_lock),
        .pll_reset  (pll_reset),
        .sys_reset  (sys_reset),
        .ready      (ready),
        .fail       (fail),
        .retries    (retries),
        .loss_count (loss_count),
        .state      (state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: phase 0..5 (reset pulse, wait, filter, hold, run, gave up), time spent in it,
    // and the last two sampled lock values standing in for the synchroniser delay.
    int m_state = 0, m_t = 0, m_s1 = 0, m_s2 = 0, m_loss = 0, m_retries = 0;

    always @(posedge clk) begin : model
        int ls, nxt;
        if (reset) begin
            m_state = 0; m_t = 0; m_s1 = 0; m_s2 = 0; m_loss = 0; m_retries = 0;
        end else begin
            ls   = m_s2;
            m_s2 = m_s1;
            m_s1 = int'(pll_lock);
            nxt  = m_state;
            case (m_state)
                0: if (m_t == RST - 1) nxt = 1;
                1: begin
                    if (ls != 0) nxt = 2;
                    else if (WD && m_t == TO - 1) begin
                        m_retries++;
                        nxt = (m_retries == MR) ? 5 : 0;
                    end
                end
                2: if (ls == 0) nxt = 1; else if (m_t == FILT - 1) nxt = 3;
                3: if (ls == 0) nxt = 1; else if (m_t == HLD - 1) nxt = 4;
                4: if (ls == 0) begin
                    nxt = 0;
                    if (m_loss < 255) m_loss++;
                end
                default: ;
            endcase
            if (nxt == 4) m_retries = 0;
            m_t     = (nxt != m_state) ? 0 : m_t + 1;
            m_state = nxt;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("pll_reset", int'(pll_reset), int'(m_state == 0 || m_state == 5));
            check("sys_reset", int'(sys_reset), int'(m_state != 4));
            check("ready", int'(ready), int'(m_state == 4));
            check("fail", int'(fail), int'(m_state == 5));
            check("retries", int'(retries), m_retries);
            check("loss_count", int'(loss_count), m_loss);
            check("state", int'(state), m_state);
        end
    end

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        bit seen;
        reset = 1'b1;
        pll_lock = 1'b0;
        wait_neg(3);
        chk_en = 1'b1;
        check("rst_pll_reset", int'(pll_reset), 1);
        check("rst_sys_reset", int'(sys_reset), 1);
        check("rst_ready", int'(ready), 0);
        check("rst_state", int'(state), 0);
        check("rst_loss", int'(loss_count), 0);
        reset = 1'b0;

        // Reset pulse: high through falling edge 3, low at 4.
        wait_neg(3);
        check("pulse_high", int'(pll_reset), 1);
        wait_neg(1);
        check("pulse_low", int'(pll_reset), 0);
        check("pulse_wait_state", int'(state), 1);
        check("pulse_sys_reset", int'(sys_reset), 1);

        // Lock at edge 10: 2 sync + 1 detect + 8 filter + 16 hold -> RUN at edge 37.
        wait_neg(6);
        pll_lock = 1'b1;
        wait_neg(26);
        check("pre_run_sys_reset", int'(sys_reset), 1);
        wait_neg(1);
        check("run_sys_reset", int'(sys_reset), 0);
        check("run_ready", int'(ready), 1);
        check("run_state", int'(state), 4);

        // Loss in RUN at edge 40 -> seen at 43.
        wait_neg(3);
        pll_lock = 1'b0;
        wait_neg(3);
        check("loss_sys_reset", int'(sys_reset), 1);
        check("loss_ready", int'(ready), 0);
        check("loss_count1", int'(loss_count), 1);
        check("loss_pll_reset", int'(pll_reset), 1);

        // Reset during HOLD.
        pll_lock = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (m_state == 3) seen = 1'b1;
        end
        check("reach_hold", int'(seen), 1);
        reset = 1'b1;
        pll_lock = 1'b0;
        wait_neg(1);
        check("hold_rst_pll_reset", int'(pll_reset), 1);
        check("hold_rst_sys_reset", int'(sys_reset), 1);
        check("hold_rst_state", int'(state), 0);
        check("hold_rst_loss", int'(loss_count), 0);
        reset = 1'b0;
        wait_neg(3);
        check("hold_rst_pulse_high", int'(pll_reset), 1);
        wait_neg(1);
        check("hold_rst_pulse_low", int'(pll_reset), 0);

        // Random lock activity with occasional resets.
        for (int seg = 0; seg < 80; seg++) begin
            int len;
            if ($urandom_range(0, 14) == 0) begin
                reset = 1'b1;
                wait_neg($urandom_range(1, 2));
                reset = 1'b0;
            end
            pll_lock = ~pll_lock;
            if (pll_lock) len = int'($urandom_range(1, 60));
            else if ($urandom_range(0, 4) == 0) len = int'($urandom_range(40, 150));
            else len = int'($urandom_range(1, 12));
            wait_neg(len);
        end

        // Lock stuck low from a fresh start.
        reset = 1'b1;
        pll_lock = 1'b0;
        wait_neg(2);
        reset = 1'b0;
`ifdef PLL_WATCHDOG_EN
        wait_neg(150);
        check("wd_retries1", int'(retries), 1);
        wait_neg(100);
        check("wd_retries2", int'(retries), 2);
        wait_neg(150);
        check("wd_fail", int'(fail), 1);
        check("wd_retries3", int'(retries), 3);
        check("wd_pll_reset", int'(pll_reset), 1);
        check("wd_state", int'(state), 5);
`else
        wait_neg(10000);
        check("nowd_state", int'(state), 1);
        check("nowd_fail", int'(fail), 0);
        check("nowd_retries", int'(retries), 0);
`endif

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
